bypass_fifo_reader: RTL

BYPASS_FIFO_READER -- requirements
Module: bypass_fifo_reader

---
 rtl/bypass_fifo_pkg.sv | 17 +
 rtl/bypass_fifo_reader_if.sv | 31 +++
 rtl/bypass_fifo_reader.sv | 93 +++++++++
 3 files changed

// File: rtl/bypass_fifo_pkg.sv
// Shared constants and FSM state type for the bypass FIFO reader.
package bypass_fifo_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Lane index width; kept at least one bit so a single-lane build still has a legal vector.
  function automatic int idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bypass_fifo_reader_if.sv
// Load-side and streaming-side signals of the bypass FIFO reader, grouped with master/slave views.
interface bypass_fifo_reader_if
  import bypass_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
);

  localparam int LEN_W = $clog2(DEPTH + 1);

  logic                   load;
  logic [LEN_W-1:0]       len;
  logic [WIDTH*DEPTH-1:0] data_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   busy;
  logic [LEN_W-1:0]       remaining;
  logic                   done;

  modport master (
    output load, len, data_in, out_ready,
    input  out_valid, out_data, busy, remaining, done
  );

  modport slave (
    input  load, len, data_in, out_ready,
    output out_valid, out_data, busy, remaining, done
  );

endinterface

// File: rtl/bypass_fifo_reader.sv
// Captures a DEPTH-lane word and streams len lanes out one per cycle (first element the cycle after load), holding under out_ready=0.
// BYPASS_FIFO_READER_MSB_FIRST_EN selects descending lane order; ascending otherwise.
module bypass_fifo_reader
  import bypass_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  bypass_fifo_reader_if.slave bus
);

  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int IDX_W = idx_bits(DEPTH);

  state_t                 state_q, state_d;
  logic [WIDTH*DEPTH-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LEN_W-1:0]       remaining_q, remaining_d;
  logic                   done_q, done_d;

  logic                   valid;
  logic                   xfer;
  logic                   len_ok;
  logic [IDX_W-1:0]       first_idx;
  logic [IDX_W-1:0]       next_idx;

  assign valid  = (state_q == DRAIN);
  assign xfer   = valid && bus.out_ready;
  assign len_ok = (bus.len != '0) && (bus.len <= LEN_W'(DEPTH));

`ifdef BYPASS_FIFO_READER_MSB_FIRST_EN
  assign first_idx = IDX_W'(bus.len - LEN_W'(1));
  assign next_idx  = idx_q - IDX_W'(1);
`else
  assign first_idx = '0;
  assign next_idx  = idx_q + IDX_W'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      idx_q       <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  // The done cycle is already IDLE, so a load presented alongside done is taken without a bubble.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load && len_ok) begin
          shadow_d    = bus.data_in;
          remaining_d = bus.len;
          idx_d       = first_idx;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer) begin
          remaining_d = remaining_q - LEN_W'(1);
          idx_d       = next_idx;
          if (remaining_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_valid = valid;
  assign bus.out_data  = shadow_q[int'(idx_q) * WIDTH +: WIDTH];
  assign bus.busy      = valid;
  assign bus.remaining = remaining_q;
  assign bus.done      = done_q;

endmodule
